hilo_mul_ctrl: RTL and testbench
================================

// Module: hilo_mul_ctrl
// PURPOSE
// EX-stage controller that issues MULT/MULTU/MADD[U]/MSUB[U] to the pipelined multiplier and owns
// the architectural HI/LO registers. Also handles MTHI/MTLO.
// Holds the multiplier operands stable until out_valid, stalls the pipeline meanwhile, then
// writes (or accumulates into) HI/LO. hi_o/lo_o feed MFHI/MFLO.
// PARAMETERS
// ACC_EN       1   1: MADD/MADDU/MSUB/MSUBU legal; 0: those ops ignored (treated as NOP)
// TIMEOUT_CYC  15  max WAIT cycles without mul_out_valid before abort (4..255)
// PORTS
// clk            in   1   clock, rising edge
// rst_n          in   1   reset: synchronous, active-low
// op_valid_i     in   1   op_i/srca_i/srcb_i valid; held by EX while stall_o=1
// op_i           in   4   0 NOP,1 MULT,2 MULTU,3 MADD,4 MADDU,5 MSUB,6 MSUBU,7 MTHI,8 MTLO; 9-15 ignored
// srca_i         in   32  rs value
// srcb_i         in   32  rt value
// flush_i        in   1   exception/flush: cancel in-flight op
// stall_o        out  1   hold EX and earlier stages (combinational)
// hi_o           out  32  architectural HI (registered)
// lo_o           out  32  architectural LO (registered)
// timeout_o      out  1   1-cycle pulse: multiply aborted by watchdog
// mul_in_valid_o out  1   to multiplier in_valid (registered)
// mul_sign_o     out  1   to multiplier sign (registered)
// mul_srca_o     out  32  to multiplier srca (registered)
// mul_srcb_o     out  32  to multiplier srcb (registered)
// mul_out_valid_i in  1   from multiplier out_valid
// mul_hi_i       in   32  from multiplier hi
// mul_lo_i       in   32  from multiplier lo
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state=IDLE; hi_o=lo_o=0; mul_*_o=0; timeout_o=0; wdog=0.
// - Mul-class op: op 1-6, or op 1-2 only when ACC_EN=0.
// - IDLE:
//   - op_valid_i & mul-class & !flush_i: latch srca/srcb into mul_srca/srcb_o, sign=(op odd),
//     save op, set mul_in_valid_o=1, go WAIT. stall_o=1 this cycle.
//   - MTHI: hi_o<=srca_i; MTLO: lo_o<=srca_i. One edge, no stall, state stays IDLE.
//   - mul_in_valid_o=0 in IDLE. This forces a multiplier count restart even when the next
//     operands repeat the previous ones.
// - WAIT: mul_* outputs held constant; wdog increments each cycle.
//   - mul_out_valid_i & MULT/MULTU: {hi_o,lo_o}<={mul_hi_i,mul_lo_i}; mul_in_valid_o<=0; go IDLE.
//     stall_o=0 this cycle, so EX advances on the same edge.
//   - mul_out_valid_i & accumulate op: latch product P, go ACC; stall_o=1.
//   - Otherwise stall_o=1.
//   - wdog reaches TIMEOUT_CYC without out_valid: go IDLE, no HI/LO write, timeout_o=1 for 1 cycle.
//     stall_o=0 that cycle.
// - ACC (1 cycle): {hi_o,lo_o} <= {hi_o,lo_o} +/- P, 64-bit modulo 2^64, no overflow flag.
//   MADD* adds, MSUB* subtracts. stall_o=0; go IDLE.
// - Latency from accept to HI/LO write, with the multiplier IP's 3-cycle stable-input rule:
//   - MULT: write at end of cycle 4 (accept = cycle 0).
//   - MADD/MSUB: write at end of cycle 5.
//   - An MFHI in the following instruction sees the new value.
// - flush_i: highest priority in every state. Go IDLE, mul_in_valid_o<=0, wdog<=0, no HI/LO write.
//   - Also cancels a same-cycle completion (WAIT+out_valid, or ACC).
//   - A same-cycle MTHI/MTLO is dropped.
//   - stall_o=0 while flush_i=1.
// - op_valid_i outside IDLE is ignored: EX is stalled and only re-presents the same op.
// - Reset mid-operation: immediate return to IDLE, HI/LO cleared; multiplier result discarded.
// TESTING
// - Reset: rst_n=0 2 cycles -> hi_o=lo_o=0, stall_o=0, mul_in_valid_o=0.
// - MULT 0xFFFFFFFF*0x2 -> {hi,lo}=0xFFFFFFFF_FFFFFFFE, written at end of cycle 4.
//   MULTU same operands -> 0x00000001_FFFFFFFE. stall_o high cycles 0-3.
// - Back-to-back MULTU 7*9 twice (identical operands) -> second issue sees IDLE gap and out_valid
//   reasserts only after 3 cycles; lo=63 both times.
// - HI=0,LO=0xFFFFFFFF via MTLO; MADDU 1*1 -> hi=1,lo=0. Then MSUB 1*1 -> hi=0,lo=0xFFFFFFFF.
// - Flush in cycle 2 of MULT 3*5 -> HI/LO unchanged, stall_o=0, state IDLE, mul_in_valid_o=0 next cycle.
// - Model tied mul_out_valid_i=0, TIMEOUT_CYC=15 -> timeout_o pulse after 15 WAIT cycles;
//   HI/LO unchanged; next MTHI 0xA5A5A5A5 writes hi_o.

Source files
------------

// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl
//   EX-stage controller for the multiply family. Issues MULT/MULTU/MADD[U]/MSUB[U]
//   to the pipelined multiplier and owns the architectural HI/LO pair. MTHI/MTLO
//   are single-edge writes handled directly from IDLE.
//
//   The multiplier only produces a result after its inputs have been held stable
//   with in_valid=1 for three cycles. This block therefore parks the operands in
//   registers, holds them for the whole WAIT state and stalls EX until the result
//   is written back.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   op_valid_i, op_i    operation from EX (held by EX while stall_o=1)
//   srca_i, srcb_i      rs / rt operand values
//   flush_i             cancel whatever is in flight; wins over everything
//   stall_o             combinational stall to EX and earlier stages
//   hi_o, lo_o          architectural HI/LO (feed MFHI/MFLO)
//   timeout_o           one-cycle pulse when the watchdog aborts a multiply
//   mul_in_valid_o, mul_sign_o, mul_srca_o, mul_srcb_o   multiplier request
//   mul_out_valid_i, mul_hi_i, mul_lo_i                  multiplier response

module hilo_mul_ctrl #(
  parameter bit ACC_EN      = 1'b1,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] srca_i,
  input  logic [31:0] srcb_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        timeout_o,
  output logic        mul_in_valid_o,
  output logic        mul_sign_o,
  output logic [31:0] mul_srca_o,
  output logic [31:0] mul_srcb_o,
  input  logic        mul_out_valid_i,
  input  logic [31:0] mul_hi_i,
  input  logic [31:0] mul_lo_i
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Watchdog value seen in the last WAIT cycle allowed before abort.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  op_q;
  logic [7:0]  wdog;
  logic [63:0] prod_q;

  // Accumulate opcodes degrade to NOP when accumulation is disabled.
  function automatic logic is_mul(input logic [3:0] op);
    if (ACC_EN) is_mul = (op >= OP_MULT) && (op <= OP_MSUBU);
    else        is_mul = (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  logic op_q_acc;
  logic op_q_sub;
  assign op_q_acc = (op_q >= OP_MADD);
  assign op_q_sub = (op_q == OP_MSUB) || (op_q == OP_MSUBU);

  // Stall drops on the cycle the result lands so EX advances on the same edge
  // as the HI/LO write; a following MFHI then reads the new value.
  always_comb begin
    stall_o = 1'b0;
    if (!flush_i) begin
      unique case (state)
        ST_IDLE: stall_o = op_valid_i && is_mul(op_i);
        ST_WAIT: begin
          if (mul_out_valid_i) stall_o = op_q_acc;
          else                 stall_o = (wdog != WD_LAST);
        end
        ST_ACC:  stall_o = 1'b0;
        default: stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      op_q           <= 4'd0;
      wdog           <= 8'd0;
      prod_q         <= 64'd0;
      hi_o           <= 32'd0;
      lo_o           <= 32'd0;
      timeout_o      <= 1'b0;
      mul_in_valid_o <= 1'b0;
      mul_sign_o     <= 1'b0;
      mul_srca_o     <= 32'd0;
      mul_srcb_o     <= 32'd0;
    end else begin
      timeout_o <= 1'b0;
      if (flush_i) begin
        // Cancels in-flight work, same-cycle completions and same-cycle MTHI/MTLO.
        state          <= ST_IDLE;
        mul_in_valid_o <= 1'b0;
        wdog           <= 8'd0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            // in_valid low for at least one cycle restarts the multiplier's
            // stability count even when operands repeat.
            mul_in_valid_o <= 1'b0;
            wdog           <= 8'd0;
            if (op_valid_i) begin
              if (is_mul(op_i)) begin
                mul_srca_o     <= srca_i;
                mul_srcb_o     <= srcb_i;
                mul_sign_o     <= op_i[0];
                op_q           <= op_i;
                mul_in_valid_o <= 1'b1;
                state          <= ST_WAIT;
              end else if (op_i == OP_MTHI) begin
                hi_o <= srca_i;
              end else if (op_i == OP_MTLO) begin
                lo_o <= srca_i;
              end
            end
          end

          ST_WAIT: begin
            if (mul_out_valid_i) begin
              mul_in_valid_o <= 1'b0;
              wdog           <= 8'd0;
              if (op_q_acc) begin
                prod_q <= {mul_hi_i, mul_lo_i};
                state  <= ST_ACC;
              end else begin
                hi_o  <= mul_hi_i;
                lo_o  <= mul_lo_i;
                state <= ST_IDLE;
              end
            end else if (wdog == WD_LAST) begin
              mul_in_valid_o <= 1'b0;
              wdog           <= 8'd0;
              timeout_o      <= 1'b1;
              state          <= ST_IDLE;
            end else begin
              wdog <= wdog + 8'd1;
            end
          end

          ST_ACC: begin
            // 64-bit wraparound accumulate, no overflow reporting.
            if (op_q_sub) {hi_o, lo_o} <= {hi_o, lo_o} - prod_q;
            else          {hi_o, lo_o} <= {hi_o, lo_o} + prod_q;
            state <= ST_IDLE;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
module tb_hilo_mul_ctrl;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n, op_valid, flush;
  logic [3:0]  op;
  logic [31:0] srca, srcb;
  logic        stall, timeout, mul_in_valid, mul_sign;
  logic [31:0] hi, lo, mul_srca, mul_srcb, mul_hi, mul_lo;
  logic        mul_out_valid;

  always #5 clk = ~clk;

  hilo_mul_ctrl #(.ACC_EN(1'b1), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid_i(op_valid), .op_i(op),
    .srca_i(srca), .srcb_i(srcb), .flush_i(flush), .stall_o(stall),
    .hi_o(hi), .lo_o(lo), .timeout_o(timeout),
    .mul_in_valid_o(mul_in_valid), .mul_sign_o(mul_sign),
    .mul_srca_o(mul_srca), .mul_srcb_o(mul_srcb),
    .mul_out_valid_i(mul_out_valid), .mul_hi_i(mul_hi), .mul_lo_i(mul_lo)
  );

  // Multiplier model: result valid once in_valid has been held for 3 cycles.
  int   mcnt = 0;
  logic mul_dead = 1'b0;
  always @(posedge clk) begin
    if (!mul_in_valid) mcnt <= 0;
    else if (mcnt < 3) mcnt <= mcnt + 1;
  end
  logic [63:0] mprod;
  always_comb begin
    if (mul_sign) mprod = {{32{mul_srca[31]}}, mul_srca} * {{32{mul_srcb[31]}}, mul_srcb};
    else          mprod = {32'd0, mul_srca} * {32'd0, mul_srcb};
  end
  assign mul_out_valid = mul_in_valid && (mcnt == 3) && !mul_dead;
  assign mul_hi = mprod[63:32];
  assign mul_lo = mprod[31:0];

  int tests = 0, fails = 0;
  logic        chk_en = 1'b0;
  logic [63:0] exp_hl = 64'd0;
  logic        exp_to = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle check of architectural state against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hilo", {hi, lo}, exp_hl);
      chk("timeout", {63'd0, timeout}, {63'd0, exp_to});
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; op_valid = 1'b0; flush = 1'b0; op = 4'd0; srca = 0; srcb = 0;
    tick;
    exp_hl = 64'd0; exp_to = 1'b0;
    tick;
    rst_n = 1'b1; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_inv", {63'd0, mul_in_valid}, 64'd0);
    tick;
  endtask

  // Issue one multiply-class op, checking stall every cycle. fc>=0 flushes in
  // that cycle; tmo expects a watchdog abort (multiplier silenced).
  task automatic run_mul(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int fc, input bit tmo);
    logic signed [63:0] sa, sb;
    logic [63:0] p, nxt;
    int L;
    bit done;
    sa = $signed(a); sb = $signed(b);
    p  = o[0] ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
    if (o <= 4'd2)      nxt = p;
    else if (o <= 4'd4) nxt = exp_hl + p;
    else                nxt = exp_hl - p;
    L = tmo ? TO : ((o <= 4'd2) ? 4 : 5);
    op_valid = 1'b1; op = o; srca = a; srcb = b;
    done = 0;
    for (int c = 0; c <= L && !done; c++) begin
      if (c == fc) flush = 1'b1;
      @(negedge clk);
      if (c == 0) chk("idle_inv", {63'd0, mul_in_valid}, 64'd0);
      if (c == 1) begin
        chk("req_a", {32'd0, mul_srca}, {32'd0, a});
        chk("req_b", {32'd0, mul_srcb}, {32'd0, b});
        chk("req_sign", {63'd0, mul_sign}, {63'd0, o[0]});
      end
      chk("stall", {63'd0, stall}, (c == fc || c >= L) ? 64'd0 : 64'd1);
      tick;
      if (c == fc) begin
        flush = 1'b0; op_valid = 1'b0; done = 1;
        @(negedge clk);
        chk("flush_inv", {63'd0, mul_in_valid}, 64'd0);
        chk("flush_stall", {63'd0, stall}, 64'd0);
        repeat (6) tick;
      end else if (c == L) begin
        op_valid = 1'b0;
        if (tmo) begin
          exp_to = 1'b1;
          tick;
          exp_to = 1'b0;
        end else begin
          exp_hl = nxt;
        end
      end
    end
  endtask

  task automatic run_mt(input logic [3:0] o, input logic [31:0] v, input bit fl);
    op_valid = 1'b1; op = o; srca = v; flush = fl;
    @(negedge clk);
    chk("mt_stall", {63'd0, stall}, 64'd0);
    tick;
    if (!fl) begin
      if (o == 4'd7) exp_hl[63:32] = v;
      else           exp_hl[31:0]  = v;
    end
    op_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    do_reset;
    // MULT / MULTU on the same operands
    run_mul(4'd1, 32'hFFFFFFFF, 32'h2, -1, 0);
    chk("pin_mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    run_mul(4'd2, 32'hFFFFFFFF, 32'h2, -1, 0);
    chk("pin_multu", {hi, lo}, 64'h00000001_FFFFFFFE);
    // back-to-back identical MULTU
    run_mul(4'd2, 32'd7, 32'd9, -1, 0);
    chk("pin_b2b_1", {hi, lo}, 64'd63);
    run_mul(4'd2, 32'd7, 32'd9, -1, 0);
    chk("pin_b2b_2", {hi, lo}, 64'd63);
    // accumulate across the 32-bit boundary
    run_mt(4'd7, 32'h0, 0);
    run_mt(4'd8, 32'hFFFFFFFF, 0);
    run_mul(4'd4, 32'd1, 32'd1, -1, 0);
    chk("pin_maddu", {hi, lo}, 64'h00000001_00000000);
    run_mul(4'd5, 32'd1, 32'd1, -1, 0);
    chk("pin_msub", {hi, lo}, 64'h00000000_FFFFFFFF);
    // flush in WAIT, flushed MTHI
    run_mul(4'd1, 32'd3, 32'd5, 2, 0);
    run_mt(4'd7, 32'h12345678, 1);
    chk("pin_flush", {hi, lo}, 64'h00000000_FFFFFFFF);
    // signed MADD with a negative operand
    run_mul(4'd3, 32'hFFFFFFFD, 32'd5, -1, 0);
    chk("pin_madd", {hi, lo}, 64'h00000000_FFFFFFF0);
    // flush on completion cycle and in ACC
    run_mul(4'd4, 32'd2, 32'd2, 4, 0);
    run_mul(4'd6, 32'd2, 32'd2, 5, 0);
    chk("pin_flush_acc", {hi, lo}, 64'h00000000_FFFFFFF0);
    // MSUBU wrap below zero
    run_mt(4'd8, 32'd0, 0);
    run_mul(4'd6, 32'd1, 32'd1, -1, 0);
    chk("pin_msubu", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
    // watchdog abort
    mul_dead = 1'b1;
    run_mul(4'd1, 32'd3, 32'd5, -1, 1);
    mul_dead = 1'b0;
    chk("pin_tmo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
    run_mt(4'd7, 32'hA5A5A5A5, 0);
    chk("pin_mthi", {hi, lo}, 64'hA5A5A5A5_FFFFFFFF);
    // reset in the middle of a multiply
    op_valid = 1'b1; op = 4'd1; srca = 32'd6; srcb = 32'd7;
    tick; tick;
    do_reset;
    chk("pin_midrst", {hi, lo}, 64'd0);
    repeat (6) tick;
    chk("pin_midrst2", {hi, lo}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
